// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM: sequences Fetch/Decode/Execute/Memory/Writeback.
// Latency: Moore outputs decoded from the state register. ImmSrc, ALUControl and BEQ PCWrite follow their inputs in the same cycle.
// Backpressure: none. The FSM advances every cycle, and synchronous reset aborts the current instruction.
//
// Ports:
//   clk, reset                     rising-edge clock, synchronous active-high reset
//   op, funct3, funct7b5, Zero     instruction fields from the IR and the ALU zero flag
//   PCWrite, AdrSrc, MemWrite,     datapath enables and mux selects
//   IRWrite, ResultSrc, ALUSrcA,
//   ALUSrcB, ImmSrc, ALUControl,
//   RegWrite
//   retire                         pulses in the last state of each instruction
//   illegal                        pulses in DECODE for an unsupported opcode
//   state                          current state code
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t state_q, state_d;
  state_t dec_state;
  logic   op_legal;
  logic   pc_write, mem_write, ir_write, reg_write, retire_i, illegal_i;
  logic [1:0] alu_op;

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: op_legal = 1'b1;
      default:                                  op_legal = 1'b0;
    endcase
  end

  // Next-state logic. Codes 11-15 fall into default and recover to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECR:   state_d = S_ALUWB;
      S_EXECI:   state_d = S_ALUWB;
      S_JAL:     state_d = S_ALUWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // During reset the selects present the FETCH decode. The enables are
  // gated separately below so that an aborted instruction cannot write.
  assign dec_state = reset ? S_FETCH : state_q;

  always_comb begin
    pc_write  = 1'b0;
    AdrSrc    = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = 2'b00;
    reg_write = 1'b0;
    retire_i  = 1'b0;
    illegal_i = 1'b0;
    case (dec_state)
      S_FETCH: begin
        ir_write  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_write  = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b01;
        illegal_i = ~op_legal;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
        retire_i  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        retire_i  = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire_i  = 1'b1;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pc_write = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        alu_op   = 2'b01;
        pc_write = Zero;
        retire_i = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWrite  = pc_write  & ~reset;
  assign MemWrite = mem_write & ~reset;
  assign IRWrite  = ir_write  & ~reset;
  assign RegWrite = reg_write & ~reset;
  assign retire   = retire_i  & ~reset;
  assign illegal  = illegal_i & ~reset;
  assign state    = state_q;

  // The immediate format depends only on the opcode, so it is valid in every state.
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // funct3=000 subtracts only for R-type (op[5]=1) with funct7b5 set.
  // addi ignores Instr[30], because that bit belongs to its immediate.
  always_comb begin
    ALUControl = ALU_ADD;
    case (alu_op)
      2'b00: ALUControl = ALU_ADD;
      2'b01: ALUControl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  ALUControl = (funct7b5 & op[5]) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, retire, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .RegWrite(RegWrite), .retire(retire), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu;
    logic       rw, ret, ill;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  function automatic exp_t mk(input logic [3:0] st, input logic pcw, adr, mw, irw,
                              input logic [1:0] res, sa, sb, imm,
                              input logic [2:0] alu, input logic rw, ret, ill);
    exp_t e;
    e.st = st; e.pcw = pcw; e.adr = adr; e.mw = mw; e.irw = irw;
    e.res = res; e.sa = sa; e.sb = sb; e.imm = imm; e.alu = alu;
    e.rw = rw; e.ret = ret; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t fetch_e(input logic [1:0] imm);
    return mk(4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0, 0, 0);
  endfunction

  function automatic exp_t decode_e(input logic [1:0] imm, input logic ill);
    return mk(4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0, 0, ill);
  endfunction

  // FETCH decode with every enable held low by reset
  function automatic exp_t rst_e(input logic [1:0] imm);
    return mk(4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0, 0, 0);
  endfunction

  task automatic push(input exp_t e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  // Each cycle: sample at the falling edge, pop the expected value and compare.
  task automatic run(input int n);
    exp_t  obs, e;
    string t;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs = '{st: state, pcw: PCWrite, adr: AdrSrc, mw: MemWrite, irw: IRWrite,
              res: ResultSrc, sa: ALUSrcA, sb: ALUSrcB, imm: ImmSrc,
              alu: ALUControl, rw: RegWrite, ret: retire, ill: illegal};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL scoreboard_underflow: observed=%h required=<queued entry>", obs);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === e) else begin
          errors++;
          $error("FAIL %s: observed=%h required=%h", t, obs, e);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_r(input logic [2:0] f3, input logic f7, input logic [2:0] alu, input string t);
    op = 7'b0110011; funct3 = f3; funct7b5 = f7;
    push(fetch_e(2'b00), {t, " fetch"});
    push(decode_e(2'b00, 0), {t, " decode"});
    push(mk(4'd6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, alu, 0, 0, 0), {t, " execr"});
    push(mk(4'd7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 1, 0), {t, " aluwb"});
    run(4);
  endtask

  task automatic do_i(input logic [2:0] f3, input logic f7, input logic [2:0] alu, input string t);
    op = 7'b0010011; funct3 = f3; funct7b5 = f7;
    push(fetch_e(2'b00), {t, " fetch"});
    push(decode_e(2'b00, 0), {t, " decode"});
    push(mk(4'd8, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, alu, 0, 0, 0), {t, " execi"});
    push(mk(4'd7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 1, 0), {t, " aluwb"});
    run(4);
  endtask

  task automatic do_beq(input logic z, input string t);
    op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = z;
    push(fetch_e(2'b10), {t, " fetch"});
    push(decode_e(2'b10, 0), {t, " decode"});
    push(mk(4'd10, z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0, 1, 0), {t, " beq"});
    run(3);
  endtask

  initial begin
    reset = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1; Zero = 1'b0;
    @(posedge clk);
    #1;
    push(rst_e(2'b00), "reset state");
    run(1);
    reset = 1'b0;

    // R-type ALU decode over several funct3/funct7b5 patterns
    do_r(3'b000, 1'b1, 3'b001, "r sub");
    do_r(3'b000, 1'b0, 3'b000, "r add");
    do_r(3'b010, 1'b0, 3'b101, "r slt");
    do_r(3'b110, 1'b0, 3'b011, "r or");
    do_r(3'b111, 1'b1, 3'b010, "r and");
    do_r(3'b100, 1'b0, 3'b000, "r xor->add");

    // Reset asserted in EXECR and held for three edges
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    push(fetch_e(2'b00), "rst-mid fetch");
    push(decode_e(2'b00, 0), "rst-mid decode");
    run(2);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    assert ({PCWrite, MemWrite, IRWrite, RegWrite, retire, illegal} === 6'b0) else begin
      errors++;
      $error("FAIL rst-mid enables: observed=%b required=000000",
             {PCWrite, MemWrite, IRWrite, RegWrite, retire, illegal});
    end
    checks++;
    assert (state === 4'd6) else begin
      errors++;
      $error("FAIL rst-mid state: observed=%0d required=6", state);
    end
    @(posedge clk);
    #1;
    push(rst_e(2'b00), "rst hold 2");
    push(rst_e(2'b00), "rst hold 3");
    run(2);
    reset = 1'b0;

    // lw, with funct3 nonzero to show that address generation still adds
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b1;
    push(fetch_e(2'b00), "lw fetch");
    push(decode_e(2'b00, 0), "lw decode");
    push(mk(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0, 0), "lw memadr");
    push(mk(4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 0), "lw memread");
    push(mk(4'd4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1, 1, 0), "lw memwb");
    run(5);

    // sw
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
    push(fetch_e(2'b01), "sw fetch");
    push(decode_e(2'b01, 0), "sw decode");
    push(mk(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0, 0, 0), "sw memadr");
    push(mk(4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 1, 0), "sw memwrite");
    run(4);

    // I-type: addi with Instr[30]=1 must still add
    do_i(3'b000, 1'b1, 3'b000, "addi f7b5");
    do_i(3'b010, 1'b0, 3'b101, "slti");
    do_i(3'b111, 1'b0, 3'b010, "andi");

    do_beq(1'b1, "beq taken");
    do_beq(1'b0, "beq not taken");

    // jal
    op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
    push(fetch_e(2'b11), "jal fetch");
    push(decode_e(2'b11, 0), "jal decode");
    push(mk(4'd9, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0, 0, 0), "jal jal");
    push(mk(4'd7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1, 1, 0), "jal aluwb");
    run(4);

    // illegal opcode, followed by a fresh FETCH
    op = 7'b0000000;
    push(fetch_e(2'b00), "illegal fetch");
    push(decode_e(2'b00, 1), "illegal decode");
    push(fetch_e(2'b00), "illegal next fetch");
    run(3);

    checks++;
    assert (exp_q.size() === 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed=%0d entries required=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
